// File: rtl/frame_mem_arbiter.sv
// Frame RAM arbiter: scanout fetch has priority, writers A/B share the rest.
// Define FRAME_MEM_ARB_VBLANK_ONLY_EN to restrict writes to vertical blanking.
module frame_mem_arbiter (
    input  logic        CLK25MHz,
    input  logic        RESET,
    input  logic [10:0] XCoord,
    input  logic [10:0] YCoord,
    output logic [7:0]  pixel_out,
    input  logic        wr_req_a,
    input  logic [14:0] wr_addr_a,
    input  logic [7:0]  wr_data_a,
    output logic        wr_ack_a,
    input  logic        wr_req_b,
    input  logic [14:0] wr_addr_b,
    input  logic [7:0]  wr_data_b,
    output logic        wr_ack_b,
    output logic [14:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [14:0] CELLS = 15'd19200;

    logic        slot_mid;
    logic        slot_end;
    logic [10:0] fetch_x;
    logic [10:0] fetch_y;
    logic        live;
    logic [14:0] row_base;
    logic [14:0] fetch_addr;
    logic        wr_window;
    logic        gnt_a;
    logic        gnt_b;
    logic        live_q;
    logic        rr_q;
    logic        rr_d;
    logic [7:0]  pixel_d;

    always_comb begin
        slot_mid = (XCoord[1:0] == 2'd2) && (XCoord < 11'd638);
        slot_end = (XCoord == 11'd798);
        fetch_x  = slot_end ? 11'd0 : XCoord + 11'd2;
        if (!slot_end)
            fetch_y = YCoord;
        else if (YCoord == 11'd524)
            fetch_y = 11'd0;
        else
            fetch_y = YCoord + 11'd1;
        live = (slot_mid || slot_end) && (fetch_y < 11'd480) && !RESET;
    end

    // row * 160 as (row << 7) + (row << 5)
    always_comb begin
        row_base   = ({6'd0, fetch_y[10:2]} << 7) + ({6'd0, fetch_y[10:2]} << 5);
        fetch_addr = row_base + {6'd0, fetch_x[10:2]};
    end

    always_comb begin
`ifdef FRAME_MEM_ARB_VBLANK_ONLY_EN
        wr_window = !live && !RESET && (YCoord >= 11'd480);
`else
        wr_window = !live && !RESET;
`endif
        gnt_a = wr_window && wr_req_a && (!wr_req_b || !rr_q);
        gnt_b = wr_window && wr_req_b && (!wr_req_a || rr_q);
    end

    always_comb begin
        mem_addr  = 15'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        wr_ack_a  = gnt_a;
        wr_ack_b  = gnt_b;
        if (live) begin
            mem_addr = fetch_addr;
        end else if (gnt_a) begin
            mem_addr  = wr_addr_a;
            mem_wdata = wr_data_a;
            mem_we    = (wr_addr_a < CELLS);
        end else if (gnt_b) begin
            mem_addr  = wr_addr_b;
            mem_wdata = wr_data_b;
            mem_we    = (wr_addr_b < CELLS);
        end
    end

    // Pointer favours the port that was not served last.
    always_comb begin
        rr_d = rr_q;
        if (gnt_a)
            rr_d = 1'b1;
        else if (gnt_b)
            rr_d = 1'b0;
        pixel_d = live_q ? mem_rdata : pixel_out;
    end

    always_ff @(posedge CLK25MHz) begin
        if (RESET) begin
            live_q    <= 1'b0;
            rr_q      <= 1'b0;
            pixel_out <= 8'd0;
        end else begin
            live_q    <= live;
            rr_q      <= rr_d;
            pixel_out <= pixel_d;
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Directed bench for frame_mem_arbiter (default build, writes in any free cycle).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_frame_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] xc;
    logic [10:0] yc;
    logic [7:0]  pixel_out;
    logic        req_a;
    logic [14:0] addr_a;
    logic [7:0]  data_a;
    logic        ack_a;
    logic        req_b;
    logic [14:0] addr_b;
    logic [7:0]  data_b;
    logic        ack_b;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  ram [0:32767];

    int checks = 0;
    int errors = 0;

    always #20 clk = ~clk;

    frame_mem_arbiter dut (
        .CLK25MHz (clk),
        .RESET    (rst),
        .XCoord   (xc),
        .YCoord   (yc),
        .pixel_out(pixel_out),
        .wr_req_a (req_a),
        .wr_addr_a(addr_a),
        .wr_data_a(data_a),
        .wr_ack_a (ack_a),
        .wr_req_b (req_b),
        .wr_addr_b(addr_b),
        .wr_data_b(data_b),
        .wr_ack_b (ack_b),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous-read frame RAM
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [10:0] x, input logic [10:0] y,
                       input logic ra, input logic [14:0] aa, input logic [7:0] da,
                       input logic rb, input logic [14:0] ab, input logic [7:0] db);
        @(negedge clk);
        rst = r;
        xc = x;
        yc = y;
        req_a = ra;
        addr_a = aa;
        data_a = da;
        req_b = rb;
        addr_b = ab;
        data_b = db;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++)
            ram[i] = 8'd0;
        ram[1] = 8'hE0;
        rst = 1'b1;
        xc = 0;
        yc = 0;
        req_a = 0;
        addr_a = 0;
        data_a = 0;
        req_b = 0;
        addr_b = 0;
        data_b = 0;

        // Reset with a live slot and a pending request
        cyc(1, 2, 0, 1, 15'd50, 8'h11, 0, 0, 0);
        cyc(1, 2, 0, 1, 15'd50, 8'h11, 0, 0, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_we", mem_we, 0);
        check("rst_ack_a", ack_a, 0);
        check("rst_ack_b", ack_b, 0);
        check("rst_pix", pixel_out, 0);

        // Scanout fetch at X=2, pixel valid from X=4
        cyc(0, 2, 0, 0, 0, 0, 0, 0, 0);
        check("fetch_addr", mem_addr, 1);
        check("fetch_we", mem_we, 0);
        cyc(0, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 4, 0, 0, 0, 0, 0, 0, 0);
        check("pix_x4", pixel_out, 8'hE0);
        cyc(0, 5, 0, 0, 0, 0, 0, 0, 0);
        check("pix_x5", pixel_out, 8'hE0);

        // End-of-line prefetch of the next line
        cyc(0, 798, 7, 0, 0, 0, 0, 0, 0);
        check("eol_addr", mem_addr, 320);
        cyc(0, 798, 479, 1, 15'd5, 8'h33, 0, 0, 0);
        check("eol479_ack", ack_a, 1);
        check("eol479_we", mem_we, 1);
        check("eol479_addr", mem_addr, 5);

        // Write blocked by slot at X=6, issued at X=7
        cyc(0, 6, 0, 1, 15'd100, 8'h1C, 0, 0, 0);
        check("x6_ack", ack_a, 0);
        check("x6_addr", mem_addr, 2);
        cyc(0, 7, 0, 1, 15'd100, 8'h1C, 0, 0, 0);
        check("x7_ack", ack_a, 1);
        check("x7_we", mem_we, 1);
        check("x7_addr", mem_addr, 100);
        check("x7_wdata", mem_wdata, 8'h1C);

        // Both ports in vblank; pointer points at B after two A grants
        for (int i = 0; i < 4; i++) begin
            cyc(0, 11'(100 + i), 490, 1, 15'd10, 8'hAA, 1, 15'd11, 8'hBB);
            check("rr_ack_a", ack_a, (i % 2 == 1) ? 1 : 0);
            check("rr_ack_b", ack_b, (i % 2 == 0) ? 1 : 0);
        end

        // Out-of-range write is acked but dropped
        cyc(0, 110, 490, 0, 0, 0, 1, 15'd19200, 8'h77);
        check("oob_ack_b", ack_b, 1);
        check("oob_we", mem_we, 0);
        check("oob_ack_a", ack_a, 0);

        // Boundaries: last cell of line, no slot at 638, wrap 524->0
        cyc(0, 634, 4, 0, 0, 0, 0, 0, 0);
        check("x634_addr", mem_addr, 15'd160 + 15'd159);
        cyc(0, 638, 0, 0, 0, 0, 1, 15'd300, 8'h44);
        check("x638_ack_b", ack_b, 1);
        check("x638_we", mem_we, 1);
        cyc(0, 798, 524, 1, 15'd9, 8'h01, 0, 0, 0);
        check("wrap_ack", ack_a, 0);
        check("wrap_we", mem_we, 0);
        check("wrap_addr", mem_addr, 0);

        // Withdrawn request leaves an idle cycle
        cyc(0, 0, 490, 0, 15'd9, 8'h01, 0, 0, 0);
        check("idle_ack", ack_a | ack_b, 0);
        check("idle_we", mem_we, 0);
        check("idle_addr", mem_addr, 0);
        check("idle_wdata", mem_wdata, 0);

        // Reset in the middle of a pending request
        cyc(0, 6, 0, 1, 15'd200, 8'h55, 0, 0, 0);
        check("mid_ack0", ack_a, 0);
        cyc(1, 7, 0, 1, 15'd200, 8'h55, 0, 0, 0);
        check("mid_rst_ack", ack_a, 0);
        check("mid_rst_we", mem_we, 0);
        cyc(1, 8, 0, 1, 15'd200, 8'h55, 0, 0, 0);
        check("mid_rst_pix", pixel_out, 0);
        cyc(0, 10, 490, 1, 15'd200, 8'h55, 0, 0, 0);
        check("post_ack", ack_a, 1);
        check("post_we", mem_we, 1);
        check("post_addr", mem_addr, 200);
        cyc(0, 11, 490, 0, 0, 0, 0, 0, 0);
        check("post_ram", ram[200], 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_mem_arbiter.md
FRAME_MEM_ARBITER -- requirements
Module: frame_mem_arbiter

Interface
REQ-001 CLK25MHz  in  1  pixel clock; all logic on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset.
REQ-003 XCoord  in  11  current horizontal count from VGA timing, 0..799.
REQ-004 YCoord  in  11  current vertical count from VGA timing, 0..524.
REQ-005 pixel_out  out  8  registered RGB332 pixel, drives VGA pixel_in.
REQ-006 wr_req_a, wr_req_b  in  1 each  write requests; A = snake engine, B = fill/clear engine.
REQ-007 wr_addr_a, wr_addr_b  in  15 each  cell address, 0..19199 (160x120 grid).
REQ-008 wr_data_a, wr_data_b  in  8 each  cell colour.
REQ-009 wr_ack_a, wr_ack_b  out  1 each  high in the cycle the request's write is issued.
REQ-010 mem_addr  out  15  single-port frame RAM address.
REQ-011 mem_we  out  1  RAM write enable.
REQ-012 mem_wdata  out  8  RAM write data.
REQ-013 mem_rdata  in  8  RAM read data, valid one cycle after address (synchronous read).

Function
REQ-014 Each 4x4 screen pixel block maps to one cell: addr = (y>>2)*160 + (x>>2), computed as shift-add, 15 bits, no overflow for in-range inputs.
REQ-015 Scanout slot occurs when XCoord[1:0]==2 and XCoord<638 (fetch x = XCoord+2, fetch y = YCoord), or when XCoord==798 (fetch x = 0, fetch y = YCoord+1, with 524 wrapping to 0).
REQ-016 A slot is live only if fetch y < 480; live slots drive mem_addr with the fetch cell, mem_we=0.
REQ-017 In the cycle after a live slot, pixel_out loads mem_rdata; pixel_out otherwise holds, so it is valid for XCoord 4k..4k+3 of the fetched cell.
REQ-018 Scanout has absolute priority; no write is issued in a live-slot cycle.
REQ-019 In any other cycle, if one requester is asserting, its write is issued: mem_addr/mem_wdata from that port, mem_we=1, its wr_ack high.
REQ-020 If both are asserting, a round-robin pointer selects; pointer moves to the other port after each granted write.
REQ-021 At most one wr_ack is high per cycle; ack never asserts without a corresponding request.
REQ-022 Requester holds req/addr/data stable until ack; deasserting before ack withdraws the request with no write.
REQ-023 A requester holding req after ack gets another write (back-to-back permitted, subject to REQ-018/020).
REQ-024 Requests with addr >= 19200 are acked but mem_we stays 0 (write dropped).
REQ-025 Idle cycles: mem_we=0, mem_addr=0, mem_wdata=0.

Reset
REQ-026 While RESET high: pixel_out=0, wr_ack_a=wr_ack_b=0, mem_we=0, mem_addr=0, round-robin pointer = A.
REQ-027 A request pending when RESET asserts is not acked and is not written; requester re-presents after reset.
REQ-028 First live slot after RESET release behaves normally; no pipeline state survives reset.

Configuration
REQ-029 Macro FRAME_MEM_ARB_VBLANK_ONLY_EN defined: writes are granted only when YCoord >= 480 (tear-free updates); requests outside vblank wait.
REQ-030 Macro undefined: writes are granted in any non-live-slot cycle per REQ-019.

Verification
REQ-031 XCoord=2, YCoord=0, mem_rdata=0xE0 next cycle -> mem_addr=1 at XCoord=2; pixel_out=0xE0 from XCoord=4.
REQ-032 XCoord=798, YCoord=7 -> mem_addr=320 (line 8, cell 0); XCoord=798, YCoord=479 -> no read, write allowed.
REQ-033 wr_req_a=1, addr 100, data 0x1C at XCoord=6 on YCoord 0 -> no ack at XCoord=6, ack at XCoord=7 with mem_we=1, mem_addr=100.
REQ-034 Both ports requesting continuously during vblank -> acks alternate A,B,A,B every cycle.
REQ-035 wr_req_b with addr 19200 -> wr_ack_b=1, mem_we=0.
REQ-036 RESET asserted mid-request with wr_req_a held -> no ack, pixel_out=0; after release, write to same addr acked within 2 cycles in blanking.
